// File: rtl/zc_fm_demod_if.sv
// ---------------------------------------------------------------------------
// zc_fm_demod_if
//   Sample/result bundle for the zero-crossing FM demodulator.
//
//   Signals
//     enableclk     sample strobe from the source
//     insample      signed sample, meaningful only while enableclk=1
//     period        last measured period in enableclk ticks
//     period_valid  one-clock pulse when period is updated
//     timeout       one-clock pulse on carrier loss
//     locked        high while a valid period stream is present
//
//   Modports
//     master  sample source / consumer of results (testbench, upstream logic)
//     slave   the demodulator itself
// ---------------------------------------------------------------------------
interface zc_fm_demod_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 20
);
    // Handshake: there is no backpressure. The demodulator consumes insample
    // on every rising clock edge where enableclk=1; the source must present a
    // new sample with each strobe. period_valid and timeout are single-clock
    // pulses that the consumer must take on the clock they are high; period
    // and locked are levels that hold until the next update.
    logic                     enableclk;
    logic signed [DATA_W-1:0] insample;
    logic        [CNT_W-1:0]  period;
    logic                     period_valid;
    logic                     timeout;
    logic                     locked;

    modport master (
        output enableclk,
        output insample,
        input  period,
        input  period_valid,
        input  timeout,
        input  locked
    );

    modport slave (
        input  enableclk,
        input  insample,
        output period,
        output period_valid,
        output timeout,
        output locked
    );
endinterface

// File: rtl/zc_fm_demod.sv
// ---------------------------------------------------------------------------
// zc_fm_demod
//   Zero-crossing FM demodulator. Measures the number of enableclk ticks
//   between successive rising zero crossings of a signed sampled sinusoid.
//   The resulting period stream is the demodulated baseband (period is
//   inversely proportional to instantaneous frequency). A hysteresis band
//   around zero rejects noise, and a tick timeout declares carrier loss.
//
//   Parameters
//     DATA_W   sample width, two's complement
//     CNT_W    width of the period counter and period output
//     HYST     hysteresis magnitude, 0 <= HYST < 2**(DATA_W-1)
//     TIMEOUT  ticks without a rising crossing that declare carrier loss
//
//   Ports
//     clock      system clock, rising edge
//     reset      synchronous, active-high
//     bus        zc_fm_demod_if.slave (enableclk, insample, period,
//                period_valid, timeout, locked)
//     state_dbg  current FSM state (0 INIT, 1 ARM, 2 HI, 3 LO)
//
//   Build option
//     ZC_FM_DEMOD_AVG4_EN  when defined, period is the truncated mean of the
//                          last four raw measurements, and period_valid /
//                          locked first assert on the fourth measurement.
// ---------------------------------------------------------------------------
module zc_fm_demod #(
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 20,
    parameter int HYST    = 0,
    parameter int TIMEOUT = 2**CNT_W - 1
) (
    input  logic                clock,
    input  logic                reset,
    zc_fm_demod_if.slave        bus,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,   // waiting for a negative sample
        S_ARM  = 2'd1,   // negative seen, waiting for the first rising crossing
        S_HI   = 2'd2,   // positive half, counting
        S_LO   = 2'd3    // negative half, counting, next POS closes a period
    } state_t;

    localparam logic signed [DATA_W-1:0] HYST_P = DATA_W'(HYST);
    localparam logic signed [DATA_W-1:0] HYST_N = -HYST_P;
    localparam logic        [CNT_W-1:0]  TO_CNT = CNT_W'(TIMEOUT);
    localparam logic        [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    // Registered state
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic               valid_q, valid_d;
    logic               timeout_q, timeout_d;
    logic               locked_q, locked_d;

    // Sample classification; samples inside the band are neither
    logic               is_pos;
    logic               is_neg;

    // Combinational helpers
    logic [CNT_W-1:0]   raw_period;
    logic               meas;      // rising crossing closes a measurement
    logic               to_hit;    // carrier-loss detected on this tick

`ifdef ZC_FM_DEMOD_AVG4_EN
    // hist_q[0] is the most recent raw period
    logic [CNT_W-1:0]   hist_q [4];
    logic [CNT_W-1:0]   hist_d [4];
    logic [1:0]         fill_q, fill_d;   // raw periods seen, saturating at 3
    logic [CNT_W+1:0]   sum4;
`endif

    assign is_pos = (bus.insample >= HYST_P);
    assign is_neg = (bus.insample <  HYST_N);

    // With TIMEOUT at the counter maximum, a crossing at cnt==TIMEOUT would
    // make cnt+1 overflow; clamp so the reported period never wraps to 0.
    assign raw_period = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        locked_d  = locked_q;
        meas      = 1'b0;
        to_hit    = 1'b0;
`ifdef ZC_FM_DEMOD_AVG4_EN
        hist_d = hist_q;
        fill_d = fill_q;
        sum4   = {2'b00, raw_period} + {2'b00, hist_q[0]}
               + {2'b00, hist_q[1]}  + {2'b00, hist_q[2]};
`endif

        if (bus.enableclk) begin
            unique case (state_q)
                S_INIT: begin
                    cnt_d = '0;
                    if (is_neg) state_d = S_ARM;
                end
                S_ARM: begin
                    // First crossing only starts the count; no measurement.
                    cnt_d = '0;
                    if (is_pos) state_d = S_HI;
                end
                S_HI: begin
                    // No rising crossing is possible in the positive half,
                    // so reaching the limit here is always carrier loss.
                    if (cnt_q == TO_CNT) begin
                        to_hit = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (is_neg) state_d = S_LO;
                    end
                end
                S_LO: begin
                    // A crossing wins over a timeout on the same tick.
                    if (is_pos) begin
                        meas    = 1'b1;
                        cnt_d   = '0;
                        state_d = S_HI;
                    end else if (cnt_q == TO_CNT) begin
                        to_hit = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = S_INIT;
            endcase
        end

        if (to_hit) begin
            // period deliberately keeps its last value
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            cnt_d     = '0;
            state_d   = S_INIT;
`ifdef ZC_FM_DEMOD_AVG4_EN
            fill_d = '0;
            for (int i = 0; i < 4; i++) hist_d[i] = '0;
`endif
        end

        if (meas) begin
`ifdef ZC_FM_DEMOD_AVG4_EN
            hist_d[0] = raw_period;
            hist_d[1] = hist_q[0];
            hist_d[2] = hist_q[1];
            hist_d[3] = hist_q[2];
            // Three earlier periods plus this one make a full window.
            if (fill_q == 2'd3) begin
                period_d = sum4[CNT_W+1:2];
                valid_d  = 1'b1;
                locked_d = 1'b1;
            end else begin
                fill_d = fill_q + 2'd1;
            end
`else
            period_d = raw_period;
            valid_d  = 1'b1;
            locked_d = 1'b1;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_INIT;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            locked_q  <= locked_d;
        end
    end

`ifdef ZC_FM_DEMOD_AVG4_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            fill_q <= '0;
            for (int i = 0; i < 4; i++) hist_q[i] <= '0;
        end else begin
            fill_q <= fill_d;
            for (int i = 0; i < 4; i++) hist_q[i] <= hist_d[i];
        end
    end
`endif

    assign bus.period       = period_q;
    assign bus.period_valid = valid_q;
    assign bus.timeout      = timeout_q;
    assign bus.locked       = locked_q;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_zc_fm_demod.sv
// ---------------------------------------------------------------------------
// tb_zc_fm_demod
//   Directed bench for zc_fm_demod (default build). Two instances share the
//   same stimulus: dut_a with HYST=0 and dut_b with HYST=100, both CNT_W=8
//   and TIMEOUT=40 so carrier loss is reached quickly.
// ---------------------------------------------------------------------------
module tb_zc_fm_demod;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;
    localparam int TO     = 40;

    logic clock;
    logic reset;
    logic [1:0] st_a, st_b;

    zc_fm_demod_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus_a ();
    zc_fm_demod_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus_b ();

    zc_fm_demod #(.DATA_W(DATA_W), .CNT_W(CNT_W), .HYST(0), .TIMEOUT(TO)) dut_a (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus_a),
        .state_dbg (st_a)
    );

    zc_fm_demod #(.DATA_W(DATA_W), .CNT_W(CNT_W), .HYST(100), .TIMEOUT(TO)) dut_b (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus_b),
        .state_dbg (st_b)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-window observations, cleared by clear_obs
    int clk_idx, tick_idx;
    int va_cnt, vb_cnt, va_clk, vb_clk;
    int pa_first, pa_last, pb_first, pb_last;
    int to_a, to_b, to_a_tick, to_b_tick;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        clk_idx = 0; tick_idx = 0;
        va_cnt = 0; vb_cnt = 0; va_clk = -1; vb_clk = -1;
        pa_first = -1; pa_last = -1; pb_first = -1; pb_last = -1;
        to_a = 0; to_b = 0; to_a_tick = -1; to_b_tick = -1;
    endtask

    // driver: one clock, outputs sampled 1 time unit after the edge
    task automatic step(input logic en, input int s);
        bus_a.enableclk = en; bus_a.insample = s;
        bus_b.enableclk = en; bus_b.insample = s;
        @(posedge clock); #1;
        clk_idx++;
        if (en) tick_idx++;
        if (bus_a.period_valid) begin
            va_cnt++; va_clk = clk_idx; pa_last = int'(bus_a.period);
            if (va_cnt == 1) pa_first = int'(bus_a.period);
        end
        if (bus_b.period_valid) begin
            vb_cnt++; vb_clk = clk_idx; pb_last = int'(bus_b.period);
            if (vb_cnt == 1) pb_first = int'(bus_b.period);
        end
        if (bus_a.timeout) begin to_a++; to_a_tick = tick_idx; end
        if (bus_b.timeout) begin to_b++; to_b_tick = tick_idx; end
    endtask

    // One enable tick followed by gap disabled clocks carrying junk samples
    task automatic tick(input int s, input int gap);
        step(1'b1, s);
        for (int g = 0; g < gap; g++)
            step(1'b0, int'($urandom_range(0, 4000)) - 2000);
    endtask

    // 5 ticks at +1000 then 5 ticks at -1000; optional +50 glitch on the
    // third negative tick
    task automatic cycle(input bit glitch, input int gap);
        for (int i = 0; i < 5; i++) tick(1000, gap);
        for (int i = 0; i < 5; i++) tick((glitch && i == 2) ? 50 : -1000, gap);
    endtask

    initial begin
        reset = 1'b1;
        clear_obs();
        repeat (3) step(1'b0, 0);
        reset = 1'b0;

        // ---- reset state
        check("rst_period_a", int'(bus_a.period), 0);
        check("rst_valid_a",  int'(bus_a.period_valid), 0);
        check("rst_timeout_a", int'(bus_a.timeout), 0);
        check("rst_locked_a", int'(bus_a.locked), 0);
        check("rst_state_a",  int'(st_a), 0);
        check("rst_locked_b", int'(bus_b.locked), 0);

        // ---- clean waveform: 1st cycle only arms (pos ignored, neg arms),
        // 2nd cycle starts the count, 3rd cycle's first tick closes period 10
        clear_obs();
        cycle(0, 0);
        cycle(0, 0);
        check("prime_no_valid_a", va_cnt, 0);
        check("prime_no_valid_b", vb_cnt, 0);
        check("prime_unlocked_a", int'(bus_a.locked), 0);
        clear_obs();
        cycle(0, 0);
        check("clean_cnt_a",    va_cnt, 1);
        check("clean_clk_a",    va_clk, 1);
        check("clean_period_a", pa_last, 10);
        check("clean_period_b", pb_last, 10);
        check("clean_locked_a", int'(bus_a.locked), 1);
        check("clean_locked_b", int'(bus_b.locked), 1);
        clear_obs();
        cycle(0, 0);
        check("clean2_cnt_a",    va_cnt, 1);
        check("clean2_period_a", pa_last, 10);

        // ---- glitch inside negative half
        // HYST=100: +50 is in the band, period stays 10.
        // HYST=0: +50 is a crossing. First glitch cycle closes 10 (tick 1)
        // then 7 (tick 8); second closes 3 (tick 1) then 7.
        clear_obs();
        cycle(1, 0);
        check("g1_cnt_a",   va_cnt, 2);
        check("g1_first_a", pa_first, 10);
        check("g1_last_a",  pa_last, 7);
        check("g1_cnt_b",   vb_cnt, 1);
        check("g1_period_b", pb_last, 10);
        clear_obs();
        cycle(1, 0);
        check("g2_first_a", pa_first, 3);
        check("g2_last_a",  pa_last, 7);
        check("g2_period_b", pb_last, 10);
        check("g2_locked_b", int'(bus_b.locked), 1);
        clear_obs();
        cycle(0, 0);
        check("g3_recover_a", pa_last, 3);
        check("g3_period_b",  pb_last, 10);

        // ---- enable every 4th clock: period counts ticks; one valid pulse
        // per 40-clock cycle, at clock 1 of the window each time
        clear_obs();
        cycle(0, 3);
        check("en4_period_a", pa_last, 10);
        check("en4_cnt_a",    va_cnt, 1);
        check("en4_clk_a",    va_clk, 1);
        check("en4_len",      clk_idx, 40);
        clear_obs();
        cycle(0, 3);
        check("en4b_cnt_a",    va_cnt, 1);
        check("en4b_clk_a",    va_clk, 1);
        check("en4b_period_b", pb_last, 10);
        check("en4b_wide_a",   int'(bus_a.period_valid), 0);

        // ---- timeout: crossing tick clears cnt; on hold tick k cnt reads k-1,
        // so cnt==TIMEOUT (40) on hold tick 41
        clear_obs();
        tick(1000, 0);
        check("to_pre_period_a", pa_last, 10);
        clear_obs();
        for (int i = 0; i < 60; i++) tick(1000, 0);
        check("to_count_a",  to_a, 1);
        check("to_tick_a",   to_a_tick, TO + 1);
        check("to_tick_b",   to_b_tick, TO + 1);
        check("to_novalid_a", va_cnt, 0);
        check("to_period_a", int'(bus_a.period), 10);
        check("to_locked_a", int'(bus_a.locked), 0);
        check("to_state_a",  int'(st_a), 0);

        // ---- crossing on the tick where cnt==TIMEOUT wins: period 41
        clear_obs();
        tick(-1000, 0);          // INIT -> ARM
        tick(1000, 0);           // ARM -> HI, cnt 0
        tick(-1000, 0);          // HI -> LO, cnt 1
        for (int i = 0; i < 39; i++) tick(-1000, 0);   // cnt 40
        tick(1000, 0);
        check("prio_period_a",  pa_last, TO + 1);
        check("prio_timeout_a", to_a, 0);
        check("prio_valid_b",   vb_cnt, 1);
        check("prio_locked_a",  int'(bus_a.locked), 1);

        // ---- reset in the middle of S_LO
        for (int i = 0; i < 3; i++) tick(-1000, 0);
        check("mid_state_a", int'(st_a), 3);
        reset = 1'b1;
        step(1'b1, -1000);
        reset = 1'b0;
        check("mr_period_a", int'(bus_a.period), 0);
        check("mr_valid_a",  int'(bus_a.period_valid), 0);
        check("mr_locked_a", int'(bus_a.locked), 0);
        check("mr_state_b",  int'(st_b), 0);
        clear_obs();
        cycle(0, 0);
        cycle(0, 0);
        check("mr_relock_wait_a", va_cnt, 0);
        check("mr_no_stale_a",    int'(bus_a.period), 0);
        clear_obs();
        cycle(0, 0);
        check("mr_relock_period_a", pa_last, 10);
        check("mr_relock_locked_b", int'(bus_b.locked), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
